// File: rtl/ball_engine.sv
// ball_engine: ball motion, wall/paddle bounces, misses and scoring for the
// two-paddle game. One ball step per rising edge of the slow game tick.
module ball_engine #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_H   = 120,
    parameter int LEFT_X     = 24,
    parameter int RIGHT_X    = 616,
    parameter int STEP       = 2,
    parameter int SERVE_WAIT = 50,
    parameter int WIN_SCORE  = 9
) (
    input  logic       slowclock,
    input  logic       reset,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       hit,
    output logic       point_l,
    output logic       point_r,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        PLAY   = 3'd2,
        SCORED = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam logic [9:0]  CX        = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CY        = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]  XMAX      = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]  YMAX      = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  STEP_V    = 10'(STEP);
    localparam logic [9:0]  Y_FLOOR   = 10'(SCREEN_H - BALL_SIZE - STEP);
    localparam logic [9:0]  X_RWALL   = 10'(SCREEN_W - BALL_SIZE - STEP);
    localparam logic [9:0]  LX        = 10'(LEFT_X);
    localparam logic [9:0]  LX_WIN    = 10'(LEFT_X + STEP);
    localparam logic [9:0]  RX_STOP   = 10'(RIGHT_X - BALL_SIZE);
    localparam logic [10:0] RX_FACE   = 11'(RIGHT_X);
    localparam logic [10:0] RX_WIN    = 11'(RIGHT_X - STEP);
    localparam logic [10:0] BALL_W    = 11'(BALL_SIZE);
    localparam logic [10:0] PADDLE_W  = 11'(PADDLE_H);
    localparam logic [7:0]  SERVE_CNT = 8'(SERVE_WAIT);
    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

    state_t     cur_state, nxt_state;
    logic       dx, dy, nxt_dx, nxt_dy;
    logic [7:0] count, nxt_count;
    logic [9:0] nxt_x, nxt_y;
    logic [3:0] nxt_score_l, nxt_score_r;
    logic       nxt_hit, nxt_point_l, nxt_point_r, nxt_game_over;
    logic [10:0] ball_right;

    // True when the ball's vertical span intersects a paddle's span
    function automatic logic overlaps(input logic [9:0] by, input logic [9:0] py);
        return (({1'b0, by} + BALL_W) > {1'b0, py}) && ({1'b0, by} < ({1'b0, py} + PADDLE_W));
    endfunction

    assign ball_right = {1'b0, ball_x} + BALL_W;
    assign state      = cur_state;

    // Register every piece of game state so all outputs come straight from flops
    always_ff @(posedge slowclock or negedge reset) begin
        if (!reset) begin
            cur_state <= IDLE;
            ball_x    <= CX;
            ball_y    <= CY;
            dx        <= 1'b0;
            dy        <= 1'b1;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            count     <= 8'd0;
            hit       <= 1'b0;
            point_l   <= 1'b0;
            point_r   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ball_x    <= nxt_x;
            ball_y    <= nxt_y;
            dx        <= nxt_dx;
            dy        <= nxt_dy;
            score_l   <= nxt_score_l;
            score_r   <= nxt_score_r;
            count     <= nxt_count;
            hit       <= nxt_hit;
            point_l   <= nxt_point_l;
            point_r   <= nxt_point_r;
            game_over <= nxt_game_over;
        end
    end

    // Next-state and next-value logic for serve, motion, bounces and scoring
    always_comb begin
        nxt_state   = cur_state;
        nxt_x       = ball_x;
        nxt_y       = ball_y;
        nxt_dx      = dx;
        nxt_dy      = dy;
        nxt_score_l = score_l;
        nxt_score_r = score_r;
        nxt_count   = count;
        nxt_hit     = 1'b0;
        nxt_point_l = 1'b0;
        nxt_point_r = 1'b0;

        case (cur_state)
            IDLE: begin
                nxt_x = CX;
                nxt_y = CY;
                if (serve) begin
                    nxt_state = WAIT;
                    nxt_count = SERVE_CNT;
                end
            end

            WAIT: begin
                nxt_count = (count != 8'd0) ? count - 8'd1 : 8'd0;
                if (count <= 8'd1) begin
                    nxt_state = PLAY;
                end
            end

            PLAY: begin
                // Vertical: bounce off floor/ceiling, otherwise step
                if (dy && (ball_y >= Y_FLOOR)) begin
                    nxt_y  = YMAX;
                    nxt_dy = 1'b0;
                end else if (!dy && (ball_y <= STEP_V)) begin
                    nxt_y  = 10'd0;
                    nxt_dy = 1'b1;
                end else if (dy) begin
                    nxt_y = ball_y + STEP_V;
                end else begin
                    nxt_y = ball_y - STEP_V;
                end

                // Horizontal: the narrow crossing window prevents late hits
                if (!dx) begin
                    if ((ball_x > LX) && (ball_x <= LX_WIN) && overlaps(ball_y, paddle_l_y)) begin
                        nxt_x   = LX;
                        nxt_dx  = 1'b1;
                        nxt_hit = 1'b1;
                    end else if (ball_x <= STEP_V) begin
                        nxt_x       = 10'd0;
                        nxt_score_r = (score_r < WIN) ? score_r + 4'd1 : score_r;
                        nxt_point_r = 1'b1;
                        nxt_state   = SCORED;
                    end else begin
                        nxt_x = ball_x - STEP_V;
                    end
                end else begin
                    if ((ball_right >= RX_WIN) && (ball_right < RX_FACE) && overlaps(ball_y, paddle_r_y)) begin
                        nxt_x   = RX_STOP;
                        nxt_dx  = 1'b0;
                        nxt_hit = 1'b1;
                    end else if (ball_x >= X_RWALL) begin
                        nxt_x       = XMAX;
                        nxt_score_l = (score_l < WIN) ? score_l + 4'd1 : score_l;
                        nxt_point_l = 1'b1;
                        nxt_state   = SCORED;
                    end else begin
                        nxt_x = ball_x + STEP_V;
                    end
                end
            end

            SCORED: begin
                // point_l/point_r are still high here and identify the scorer
                if ((point_r && (score_r == WIN)) || (point_l && (score_l == WIN))) begin
                    nxt_state = OVER;
                end else begin
                    nxt_x     = CX;
                    nxt_y     = CY;
                    nxt_dx    = point_l;
                    nxt_count = SERVE_CNT;
                    nxt_state = WAIT;
                end
            end

            OVER: begin
                if (serve) begin
                    nxt_score_l = 4'd0;
                    nxt_score_r = 4'd0;
                    nxt_x       = CX;
                    nxt_y       = CY;
                    nxt_dx      = 1'b0;
                    nxt_count   = SERVE_CNT;
                    nxt_state   = WAIT;
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase

        nxt_game_over = (nxt_state == OVER);
    end

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: randomized scoreboard bench for ball_engine against a
// position/velocity reference model of the game rules.
module tb_ball_engine;

    localparam int CX    = 316;
    localparam int CY    = 236;
    localparam int XMAX  = 632;
    localparam int YMAX  = 472;
    localparam int STEP  = 2;
    localparam int LX    = 24;
    localparam int RX    = 616;
    localparam int BS    = 8;
    localparam int PH    = 120;
    localparam int SW    = 50;
    localparam int WIN   = 9;

    localparam int P_IDLE = 0, P_WAIT = 1, P_PLAY = 2, P_SCORED = 3, P_OVER = 4;

    logic       slowclock = 1'b0;
    logic       reset;
    logic [9:0] paddle_l_y, paddle_r_y;
    logic       serve;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_l, score_r;
    logic       hit, point_l, point_r, game_over;
    logic [2:0] state;

    ball_engine dut (
        .slowclock  (slowclock),
        .reset      (reset),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .serve      (serve),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .hit        (hit),
        .point_l    (point_l),
        .point_r    (point_r),
        .game_over  (game_over),
        .state      (state)
    );

    // Free-running game tick
    always #5 slowclock = ~slowclock;

    typedef struct {
        int x; int y; int sl; int sr;
        int hit; int pl; int pr; int go; int st;
    } exp_t;

    exp_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Reference model: position plus signed velocity per axis
    int m_phase, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_cnt;
    int m_hit, m_pl, m_pr, m_last_right;

    task automatic model_reset();
        m_phase = P_IDLE; m_x = CX; m_y = CY; m_vx = -STEP; m_vy = STEP;
        m_sl = 0; m_sr = 0; m_cnt = 0; m_hit = 0; m_pl = 0; m_pr = 0;
        m_last_right = 0;
    endtask

    task automatic model_tick(input int sv, input int pl, input int pr);
        int nx, ny, winner;
        m_hit = 0; m_pl = 0; m_pr = 0;
        case (m_phase)
            P_IDLE: begin
                m_x = CX; m_y = CY;
                if (sv != 0) begin m_phase = P_WAIT; m_cnt = SW; end
            end
            P_WAIT: begin
                if (m_cnt == 1) m_phase = P_PLAY;
                m_cnt = m_cnt - 1;
            end
            P_PLAY: begin
                if (m_vy > 0 && m_y >= YMAX - STEP) begin ny = YMAX; m_vy = -STEP; end
                else if (m_vy < 0 && m_y <= STEP) begin ny = 0; m_vy = STEP; end
                else ny = m_y + m_vy;
                if (m_vx < 0) begin
                    if (m_x > LX && m_x <= LX + STEP && m_y + BS > pl && m_y < pl + PH) begin
                        nx = LX; m_vx = STEP; m_hit = 1;
                    end else if (m_x <= STEP) begin
                        nx = 0; if (m_sr < WIN) m_sr++; m_pr = 1;
                        m_last_right = 1; m_phase = P_SCORED;
                    end else nx = m_x - STEP;
                end else begin
                    if (m_x + BS >= RX - STEP && m_x + BS < RX && m_y + BS > pr && m_y < pr + PH) begin
                        nx = RX - BS; m_vx = -STEP; m_hit = 1;
                    end else if (m_x >= XMAX - STEP) begin
                        nx = XMAX; if (m_sl < WIN) m_sl++; m_pl = 1;
                        m_last_right = 0; m_phase = P_SCORED;
                    end else nx = m_x + STEP;
                end
                m_x = nx; m_y = ny;
            end
            P_SCORED: begin
                winner = m_last_right ? m_sr : m_sl;
                if (winner == WIN) m_phase = P_OVER;
                else begin
                    m_x = CX; m_y = CY;
                    m_vx = m_last_right ? -STEP : STEP;
                    m_cnt = SW; m_phase = P_WAIT;
                end
            end
            default: begin
                if (sv != 0) begin
                    m_sl = 0; m_sr = 0; m_x = CX; m_y = CY; m_vx = -STEP;
                    m_cnt = SW; m_phase = P_WAIT;
                end
            end
        endcase
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.x = m_x; e.y = m_y; e.sl = m_sl; e.sr = m_sr;
        e.hit = m_hit; e.pl = m_pl; e.pr = m_pr;
        e.go = (m_phase == P_OVER) ? 1 : 0; e.st = m_phase;
        return e;
    endfunction

    function automatic exp_t reset_view();
        exp_t e;
        e.x = CX; e.y = CY; e.sl = 0; e.sr = 0;
        e.hit = 0; e.pl = 0; e.pr = 0; e.go = 0; e.st = P_IDLE;
        return e;
    endfunction

    // Compare every DUT output against one expected record
    task automatic check_output(input exp_t e, input string name);
        logic ok;
        vectors++;
        ok = (ball_x === 10'(e.x)) && (ball_y === 10'(e.y)) &&
             (score_l === 4'(e.sl)) && (score_r === 4'(e.sr)) &&
             (hit === 1'(e.hit)) && (point_l === 1'(e.pl)) && (point_r === 1'(e.pr)) &&
             (game_over === 1'(e.go)) && (state === 3'(e.st));
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got x=%0d y=%0d sc=%0d/%0d hit=%0d pl=%0d pr=%0d go=%0d st=%0d, required x=%0d y=%0d sc=%0d/%0d hit=%0d pl=%0d pr=%0d go=%0d st=%0d",
                     name, $time, ball_x, ball_y, score_l, score_r, hit, point_l, point_r, game_over, state,
                     e.x, e.y, e.sl, e.sr, e.hit, e.pl, e.pr, e.go, e.st);
        end
    endtask

    // Drive one tick of inputs and queue the response the model predicts
    task automatic apply_stimulus(input int rst_hi, input int sv, input int pl, input int pr);
        @(negedge slowclock);
        reset      = (rst_hi != 0);
        serve      = (sv != 0);
        paddle_l_y = 10'(pl);
        paddle_r_y = 10'(pr);
        if (rst_hi == 0) model_reset();
        else model_tick(sv, pl, pr);
        exp_q.push_back(model_view());
    endtask

    // Assert reset between edges and require reset values without a clock edge
    task automatic async_reset_check();
        @(negedge slowclock);
        #2 reset = 1'b0;
        #1 check_output(reset_view(), "async_reset");
        model_reset();
        exp_q.push_back(model_view());
    endtask

    function automatic int clamp_paddle(input int p);
        if (p < 0) return 0;
        if (p > 360) return 360;
        return p;
    endfunction

    function automatic int rand_paddle();
        if ($urandom_range(0, 1) == 1)
            return clamp_paddle(m_y + 4 - int'($urandom_range(0, 127)));
        return int'($urandom_range(0, 360));
    endfunction

    function automatic int miss_paddle();
        return (m_y >= 240) ? 0 : 360;
    endfunction

    task automatic bound_fail(input string name, input int got, input int want);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got phase=%0d, required phase=%0d within budget", name, got, want);
    endtask

    // Monitor: one expected record per tick, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge slowclock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e, "tick");
            end
        end
    end

    // Stimulus sequence
    initial begin
        int n;
        reset = 1'b0; serve = 1'b0; paddle_l_y = '0; paddle_r_y = '0;
        model_reset();

        repeat (3) apply_stimulus(0, 0, 0, 0);
        for (int i = 0; i < 100; i++) apply_stimulus(1, 0, rand_paddle(), rand_paddle());

        $display("[TB] serve latency, wall bounce and left hit scenario");
        apply_stimulus(1, 1, 360, 200);
        for (int i = 0; i < 220; i++) apply_stimulus(1, int'($urandom_range(0, 1)), 360, rand_paddle());

        $display("[TB] randomized play");
        for (int i = 0; i < 1500; i++)
            apply_stimulus(1, ($urandom_range(0, 15) == 0) ? 1 : 0, rand_paddle(), rand_paddle());

        async_reset_check();
        apply_stimulus(1, 1, 0, 0);

        $display("[TB] forced misses to game over");
        n = 0;
        while (m_phase != P_OVER && n < 4000) begin
            apply_stimulus(1, 0, miss_paddle(), miss_paddle());
            n++;
        end
        if (m_phase != P_OVER) bound_fail("reach_over", m_phase, P_OVER);
        for (int i = 0; i < 20; i++) apply_stimulus(1, 0, rand_paddle(), rand_paddle());
        apply_stimulus(1, 1, 0, 0);

        n = 0;
        while (m_phase != P_PLAY && n < 200) begin
            apply_stimulus(1, 0, rand_paddle(), rand_paddle());
            n++;
        end
        if (m_phase != P_PLAY) bound_fail("reach_play", m_phase, P_PLAY);
        for (int i = 0; i < 30; i++) apply_stimulus(1, 0, miss_paddle(), miss_paddle());

        $display("[TB] reset mid-play");
        async_reset_check();
        for (int i = 0; i < 10; i++) apply_stimulus(1, 0, rand_paddle(), rand_paddle());

        repeat (2) @(posedge slowclock);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending records, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ball_engine.md
# ball_engine

Ball motion and scoring stage that sits directly downstream of the two paddle blocks. It consumes both paddle vertical positions and owns the ball position, its direction, wall and paddle bounces, misses, and both players' scores. It runs off the same slow game-tick clock as the paddles: one ball step per tick. Its outputs drive the pixel renderer and score display.

## Interface
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `BALL_SIZE`, 8: square ball edge in pixels.
- `PADDLE_H`, 120: paddle height; paddle_y range is 0..SCREEN_H-PADDLE_H.
- `LEFT_X`, 24: x of the left paddle inner face.
- `RIGHT_X`, 616: x of the right paddle inner face.
- `STEP`, 2: pixels moved per tick, on each axis.
- `SERVE_WAIT`, 50: ticks spent in WAIT before play, 1..255.
- `WIN_SCORE`, 9: score that ends the game, 1..15.
- `slowclock`  in  1  game tick clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `paddle_l_y`  in  10  left paddle top y.
- `paddle_r_y`  in  10  right paddle top y.
- `serve`  in  1  level; starts play from IDLE or OVER.
- `ball_x`  out  10  ball left x.
- `ball_y`  out  10  ball top y.
- `score_l`  out  4  left player score.
- `score_r`  out  4  right player score.
- `hit`  out  1  one-tick pulse on any paddle bounce.
- `point_l`  out  1  one-tick pulse when the left player scores.
- `point_r`  out  1  one-tick pulse when the right player scores.
- `game_over`  out  1  high while in OVER.
- `state`  out  3  FSM state: IDLE=0, WAIT=1, PLAY=2, SCORED=3, OVER=4.

## Operation
- Centre position: CX=(SCREEN_W-BALL_SIZE)/2=316, CY=(SCREEN_H-BALL_SIZE)/2=236. Limits: XMAX=SCREEN_W-BALL_SIZE=632, YMAX=SCREEN_H-BALL_SIZE=472.
- Direction flags: dx (0=left, 1=right) and dy (0=up, 1=down).
- Reset values: state IDLE, ball at (316,236), dx=left, dy=down, scores 0, counter 0, all pulses 0, game_over 0.
- IDLE: ball is held at centre. When serve=1, go to WAIT and load the counter with SERVE_WAIT.
- WAIT: ball holds. The counter decrements every tick; on the tick the counter reads 1, go to PLAY. serve is ignored in this state.
- PLAY, vertical, evaluated every tick on current values:
  - dy=down and ball_y>=YMAX-STEP: ball_y=YMAX, dy=up.
  - dy=up and ball_y<=STEP: ball_y=0, dy=down.
  - Otherwise ball_y moves by ±STEP.
- PLAY, horizontal, left side (dx=left):
  - If LEFT_X<ball_x<=LEFT_X+STEP and the ball overlaps the left paddle (ball_y+BALL_SIZE>paddle_l_y and ball_y<paddle_l_y+PADDLE_H): ball_x=LEFT_X, dx=right, hit=1.
  - Else if ball_x<=STEP: ball_x=0, score_r+1, point_r=1, go to SCORED.
  - Else ball_x-=STEP.
- PLAY, horizontal, right side (dx=right), mirrored:
  - Crossing condition: RIGHT_X-STEP<=ball_x+BALL_SIZE<RIGHT_X. On overlap with the right paddle: ball_x=RIGHT_X-BALL_SIZE, dx=left, hit=1.
  - Score condition: ball_x>=XMAX-STEP. Then ball_x=XMAX, score_l+1, point_l=1.
- Once the ball has passed a paddle face it is never checked against that paddle again; no late hits.
- Vertical and horizontal updates apply in the same tick, so a corner bounce and a paddle hit may coincide. Paddle overlap uses the paddle_y sampled on that tick.
- SCORED lasts exactly one tick:
  - If the incremented score equals WIN_SCORE, go to OVER. The ball holds.
  - Otherwise recentre the ball, set dx toward the player who conceded, keep dy, load the counter, and go to WAIT.
- OVER: game_over=1 and scores are frozen. When serve=1, clear both scores, recentre the ball, set dx=left, load the counter, and go to WAIT.
- Scores saturate at WIN_SCORE and never wrap.

## Timing
- All outputs are registered; no combinational path from input to output.
- hit, point_l and point_r are high for exactly the one tick following the triggering evaluation.
- Score and ball_x update on the same edge as their pulse.
- Serve to first ball movement: WAIT occupies SERVE_WAIT ticks, and the ball first moves on the first PLAY tick.
- Reset low at any time, including mid-PLAY or in SCORED, forces all reset values immediately and asynchronously. Pulses are cleared with no residual pulse after release.

## Test plan
- Reset: drive reset=0, then release. Require ball (316,236), scores 0/0, state 0, all pulses 0. Hold serve=0 for 100 ticks: nothing moves.
- Serve latency: pulse serve. Require state=1 for 50 ticks, state=2 on the next tick, and ball_x=314, ball_y=238 one tick after that.
- Top/bottom wall: paddle_l_y=360. Require ball_y=472 on PLAY tick 118, then dy flips and ball_y=470 on tick 119.
- Left hit: paddle_l_y=360. Require ball_x=26 after PLAY tick 145. On tick 146: ball_x=24, ball_y=416, hit=1 for one tick, and ball_x=26 on tick 147.
- Left miss: paddle_l_y=0. Require no hit, ball_x reaches 0, and score_r=1 with point_r=1 for one tick. SCORED lasts one tick, then WAIT with ball (316,236) and dx=left.
- Game over and reset: force 9 misses. Require game_over=1 and score_r=9 frozen; serve then clears scores and enters WAIT. Assert reset mid-PLAY: require immediate reset values.
